alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//   Decode->Execute pipeline register and operand-forwarding stage that drives the ALU operands.
//   Captures decoded operands and control, and resolves RAW hazards by forwarding from Memory/Writeback.
//   Detects load-use hazards: stalls Decode and inserts a bubble into Execute.
//   Outputs SrcAE/SrcBE/ALUControlE connect straight to the ALU SrcA/SrcB/ALUControl inputs.
// PARAMETERS
//   WIDTH       32  datapath width
//   REG_AW      5   register-index width
//   FWD_EN      1   1 = forwarding on; 0 = bypass network disabled (raw RD1E/RD2E used)
// PORTS
//   clk          in   1       single clock, rising edge
//   reset_n      in   1       synchronous, active-low reset
//   RD1D         in   WIDTH   register-file read data 1 (Decode)
//   RD2D         in   WIDTH   register-file read data 2 (Decode)
//   ImmExtD      in   WIDTH   sign-extended immediate (Decode)
//   Rs1D         in   REG_AW  source register index 1 (Decode)
//   Rs2D         in   REG_AW  source register index 2 (Decode)
//   RdD          in   REG_AW  destination register index (Decode)
//   ALUControlD  in   3       ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt
//   ALUSrcD      in   1       1 = SrcB takes the immediate
//   RegWriteD    in   1       instruction writes Rd
//   MemReadD     in   1       instruction is a load
//   ValidD       in   1       Decode holds a real instruction
//   FlushE       in   1       squash the instruction entering Execute (branch redirect)
//   ALUResultM   in   WIDTH   Memory-stage result, forward source
//   RdM          in   REG_AW  Memory-stage destination
//   RegWriteM    in   1       Memory-stage write enable
//   ResultW      in   WIDTH   Writeback result, forward source
//   RdW          in   REG_AW  Writeback destination
//   RegWriteW    in   1       Writeback write enable
//   StallD       out  1       hold Fetch/Decode this cycle (combinational)
//   SrcAE        out  WIDTH   ALU operand A
//   SrcBE        out  WIDTH   ALU operand B
//   WriteDataE   out  WIDTH   forwarded rs2 value, for stores
//   ALUControlE  out  3       registered ALU op
//   RdE          out  REG_AW  registered destination index
//   RegWriteE    out  1       registered write enable (0 for a bubble)
//   MemReadE     out  1       registered load flag (0 for a bubble)
//   ValidE       out  1       Execute holds a real instruction
// BEHAVIOUR
//   - Execute register: all fields, plus Rs1E/Rs2E/RD1E/RD2E/ImmExtE/ALUSrcE, update on each rising clk edge.
//   - Next-state priority: !reset_n > FlushE > load-use bubble > capture of the Decode fields.
//   - Reset/bubble value: every E field 0, so ALUControlE=000, ValidE=0, RegWriteE=0, MemReadE=0.
//   - After reset, SrcAE=SrcBE=WriteDataE=0 until the first capture.
//   - Load-use hazard: StallD = MemReadE & RegWriteE & (RdE!=0) & ValidD & ((Rs1D==RdE)|(Rs2D==RdE)).
//     - When StallD=1, the next E value is a bubble.
//     - Upstream holds Decode, and the instruction is captured one cycle later, so the load-use penalty is exactly 1 cycle.
//   - StallD is forced to 0 while reset_n=0.
//   - FlushE together with a load-use hazard: the E stage takes a bubble; StallD still asserts.
//   - Forwarding, combinational from the E-stage registers; same rule for rs1 (ForwardA) and rs2 (ForwardB):
//     - use M when RegWriteM & RdM!=0 & RdM==RsE;
//     - else use W when RegWriteW & RdW!=0 & RdW==RsE;
//     - else use RD1E / RD2E.
//     - M has priority over W.
//     - Register 0 is never forwarded.
//     - With FWD_EN=0, forwarding is always from the register file.
//   - SrcAE = fwdA.  WriteDataE = fwdB.  SrcBE = ALUSrcE ? ImmExtE : fwdB.
//   - Latency: Decode->Execute 1 cycle; forwarding adds 0 cycles.
//   - No arithmetic is done in this block; widths pass through unchanged.
//   - Reset asserted mid-stall: the E stage is cleared on that edge, and StallD drops in the same cycle.
// TESTING
//   1. Reset: hold reset_n=0 for 2 cycles -> all E outputs 0, StallD=0; release -> first capture on the next edge.
//   2. M forward: E has Rs1E=5; RdM=5, RegWriteM=1, ALUResultM=0x1234 -> SrcAE=0x1234.
//      Same with RdW=5, ResultW=0xBEEF -> M wins, SrcAE=0x1234.
//   3. x0 guard: RdM=0, RegWriteM=1, Rs1E=0, RD1E=0 -> SrcAE=0; ALUSrcE=1, ImmExtE=0xFFFFFFFC -> SrcBE=0xFFFFFFFC.
//   4. Load-use: lw x3 in E (MemReadE=1), add x4,x3,x1 in D -> StallD=1 for 1 cycle, then a bubble (ValidE=0).
//      Next cycle: add captured, SrcAE = ResultW from the W forward.
//   5. Flush: FlushE=1 with a valid sub in D -> next-cycle ValidE=0, RegWriteE=0, ALUControlE=000.
//      Flush during load-use -> bubble, StallD=1.
//   6. FWD_EN=0 build: the scenario 2 stimulus -> SrcAE=RD1E (no forward).

Source files
------------

// File: rtl/alu_issue_if.sv
// Signal bundle between Decode, the Decode->Execute issue stage and the ALU.
// The master side is the Decode/hazard environment; the slave side is the issue stage.
interface alu_issue_if #(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5
);
    // Decode-stage instruction fields
    logic [WIDTH-1:0]  RD1D;
    logic [WIDTH-1:0]  RD2D;
    logic [WIDTH-1:0]  ImmExtD;
    logic [REG_AW-1:0] Rs1D;
    logic [REG_AW-1:0] Rs2D;
    logic [REG_AW-1:0] RdD;
    logic [2:0]        ALUControlD;
    logic              ALUSrcD;
    logic              RegWriteD;
    logic              MemReadD;
    logic              ValidD;
    logic              FlushE;

    // Forwarding sources from later stages
    logic [WIDTH-1:0]  ALUResultM;
    logic [REG_AW-1:0] RdM;
    logic              RegWriteM;
    logic [WIDTH-1:0]  ResultW;
    logic [REG_AW-1:0] RdW;
    logic              RegWriteW;

    // Execute-stage outputs
    logic              StallD;
    logic [WIDTH-1:0]  SrcAE;
    logic [WIDTH-1:0]  SrcBE;
    logic [WIDTH-1:0]  WriteDataE;
    logic [2:0]        ALUControlE;
    logic [REG_AW-1:0] RdE;
    logic              RegWriteE;
    logic              MemReadE;
    logic              ValidE;

    modport master (
        output RD1D, RD2D, ImmExtD, Rs1D, Rs2D, RdD, ALUControlD, ALUSrcD,
               RegWriteD, MemReadD, ValidD, FlushE,
               ALUResultM, RdM, RegWriteM, ResultW, RdW, RegWriteW,
        input  StallD, SrcAE, SrcBE, WriteDataE, ALUControlE, RdE,
               RegWriteE, MemReadE, ValidE
    );

    modport slave (
        input  RD1D, RD2D, ImmExtD, Rs1D, Rs2D, RdD, ALUControlD, ALUSrcD,
               RegWriteD, MemReadD, ValidD, FlushE,
               ALUResultM, RdM, RegWriteM, ResultW, RdW, RegWriteW,
        output StallD, SrcAE, SrcBE, WriteDataE, ALUControlE, RdE,
               RegWriteE, MemReadE, ValidE
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Decode->Execute pipeline register with operand forwarding from Memory/Writeback
// and load-use hazard detection. Drives the ALU operands directly.
module alu_issue_stage #(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5,
    parameter int FWD_EN = 1
) (
    input logic        clk,
    input logic        reset_n,
    alu_issue_if.slave bus
);

    // Execute-stage register fields
    logic [WIDTH-1:0]  rd1_e_q, rd1_e_d;
    logic [WIDTH-1:0]  rd2_e_q, rd2_e_d;
    logic [WIDTH-1:0]  imm_ext_e_q, imm_ext_e_d;
    logic [REG_AW-1:0] rs1_e_q, rs1_e_d;
    logic [REG_AW-1:0] rs2_e_q, rs2_e_d;
    logic [REG_AW-1:0] rd_e_q, rd_e_d;
    logic [2:0]        alu_control_e_q, alu_control_e_d;
    logic              alu_src_e_q, alu_src_e_d;
    logic              reg_write_e_q, reg_write_e_d;
    logic              mem_read_e_q, mem_read_e_d;
    logic              valid_e_q, valid_e_d;

    logic              load_use;
    logic [WIDTH-1:0]  fwd_a;
    logic [WIDTH-1:0]  fwd_b;

    // A later stage supplies the operand when it writes a non-zero register matching the source.
    function automatic logic fwd_hit(input logic we, input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs);
        return we && (rd != '0) && (rd == rs);
    endfunction

    // Load in Execute whose destination is read by the valid instruction in Decode.
    assign load_use = mem_read_e_q && reg_write_e_q && (rd_e_q != '0) && bus.ValidD &&
                      ((bus.Rs1D == rd_e_q) || (bus.Rs2D == rd_e_q));

    assign bus.StallD = reset_n && load_use;

    // Next Execute contents: capture Decode unless a flush or load-use bubble squashes it.
    always_comb begin
        // NOTE: every _d is given its capture value before any condition, so no path
        // leaves it unassigned and no latch is inferred.
        rd1_e_d         = bus.RD1D;
        rd2_e_d         = bus.RD2D;
        imm_ext_e_d     = bus.ImmExtD;
        rs1_e_d         = bus.Rs1D;
        rs2_e_d         = bus.Rs2D;
        rd_e_d          = bus.RdD;
        alu_control_e_d = bus.ALUControlD;
        alu_src_e_d     = bus.ALUSrcD;
        reg_write_e_d   = bus.RegWriteD;
        mem_read_e_d    = bus.MemReadD;
        valid_e_d       = bus.ValidD;
        if (bus.FlushE || load_use) begin
            rd1_e_d         = '0;
            rd2_e_d         = '0;
            imm_ext_e_d     = '0;
            rs1_e_d         = '0;
            rs2_e_d         = '0;
            rd_e_d          = '0;
            alu_control_e_d = '0;
            alu_src_e_d     = 1'b0;
            reg_write_e_d   = 1'b0;
            mem_read_e_d    = 1'b0;
            valid_e_d       = 1'b0;
        end
    end

    // Execute register with synchronous clear to the bubble value.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every field samples its pre-edge _d value together.
        if (!reset_n) begin
            rd1_e_q         <= '0;
            rd2_e_q         <= '0;
            imm_ext_e_q     <= '0;
            rs1_e_q         <= '0;
            rs2_e_q         <= '0;
            rd_e_q          <= '0;
            alu_control_e_q <= '0;
            alu_src_e_q     <= 1'b0;
            reg_write_e_q   <= 1'b0;
            mem_read_e_q    <= 1'b0;
            valid_e_q       <= 1'b0;
        end else begin
            rd1_e_q         <= rd1_e_d;
            rd2_e_q         <= rd2_e_d;
            imm_ext_e_q     <= imm_ext_e_d;
            rs1_e_q         <= rs1_e_d;
            rs2_e_q         <= rs2_e_d;
            rd_e_q          <= rd_e_d;
            alu_control_e_q <= alu_control_e_d;
            alu_src_e_q     <= alu_src_e_d;
            reg_write_e_q   <= reg_write_e_d;
            mem_read_e_q    <= mem_read_e_d;
            valid_e_q       <= valid_e_d;
        end
    end

    // Operand bypass: Memory beats Writeback, register file is the fallback.
    always_comb begin
        fwd_a = rd1_e_q;
        fwd_b = rd2_e_q;
        if (FWD_EN != 0) begin
            if (fwd_hit(bus.RegWriteM, bus.RdM, rs1_e_q))
                fwd_a = bus.ALUResultM;
            else if (fwd_hit(bus.RegWriteW, bus.RdW, rs1_e_q))
                fwd_a = bus.ResultW;
            if (fwd_hit(bus.RegWriteM, bus.RdM, rs2_e_q))
                fwd_b = bus.ALUResultM;
            else if (fwd_hit(bus.RegWriteW, bus.RdW, rs2_e_q))
                fwd_b = bus.ResultW;
        end
    end

    assign bus.SrcAE       = fwd_a;
    assign bus.WriteDataE  = fwd_b;
    assign bus.SrcBE       = alu_src_e_q ? imm_ext_e_q : fwd_b;
    assign bus.ALUControlE = alu_control_e_q;
    assign bus.RdE         = rd_e_q;
    assign bus.RegWriteE   = reg_write_e_q;
    assign bus.MemReadE    = mem_read_e_q;
    assign bus.ValidE      = valid_e_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: a reference model of the Execute register predicts each
// capture, the prediction is queued when Decode is driven and popped after the edge.
// A second instance built without forwarding shares the same stimulus.
module tb_alu_issue_stage;

    localparam int WIDTH  = 32;
    localparam int REG_AW = 5;

    logic clk;
    logic reset_n;

    alu_issue_if #(.WIDTH(WIDTH), .REG_AW(REG_AW)) bus ();
    alu_issue_if #(.WIDTH(WIDTH), .REG_AW(REG_AW)) bus0 ();

    alu_issue_stage #(.WIDTH(WIDTH), .REG_AW(REG_AW), .FWD_EN(1)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    alu_issue_stage #(.WIDTH(WIDTH), .REG_AW(REG_AW), .FWD_EN(0)) dut_nofwd (
        .clk(clk), .reset_n(reset_n), .bus(bus0)
    );

    // The no-forward instance sees exactly the same inputs.
    assign bus0.RD1D        = bus.RD1D;
    assign bus0.RD2D        = bus.RD2D;
    assign bus0.ImmExtD     = bus.ImmExtD;
    assign bus0.Rs1D        = bus.Rs1D;
    assign bus0.Rs2D        = bus.Rs2D;
    assign bus0.RdD         = bus.RdD;
    assign bus0.ALUControlD = bus.ALUControlD;
    assign bus0.ALUSrcD     = bus.ALUSrcD;
    assign bus0.RegWriteD   = bus.RegWriteD;
    assign bus0.MemReadD    = bus.MemReadD;
    assign bus0.ValidD      = bus.ValidD;
    assign bus0.FlushE      = bus.FlushE;
    assign bus0.ALUResultM  = bus.ALUResultM;
    assign bus0.RdM         = bus.RdM;
    assign bus0.RegWriteM   = bus.RegWriteM;
    assign bus0.ResultW     = bus.ResultW;
    assign bus0.RdW         = bus.RdW;
    assign bus0.RegWriteW   = bus.RegWriteW;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0]  rd1;
        logic [WIDTH-1:0]  rd2;
        logic [WIDTH-1:0]  imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [2:0]        alu;
        logic              alu_src;
        logic              rw;
        logic              mr;
        logic              valid;
    } e_t;

    e_t exp_q[$];
    e_t cur_e;
    int n_vec;
    int n_miss;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference forwarding rule.
    function automatic logic [WIDTH-1:0] model_fwd(input logic [REG_AW-1:0] rs,
                                                   input logic [WIDTH-1:0] rf, input bit en);
        if (en && bus.RegWriteM && bus.RdM != 0 && bus.RdM == rs) return bus.ALUResultM;
        if (en && bus.RegWriteW && bus.RdW != 0 && bus.RdW == rs) return bus.ResultW;
        return rf;
    endfunction

    task automatic check_src(input string tag);
        logic [WIDTH-1:0] fb;
        fb = model_fwd(cur_e.rs2, cur_e.rd2, 1'b1);
        check({tag, ":srca"}, bus.SrcAE, model_fwd(cur_e.rs1, cur_e.rd1, 1'b1));
        check({tag, ":srcb"}, bus.SrcBE, cur_e.alu_src ? cur_e.imm : fb);
        check({tag, ":wdata"}, bus.WriteDataE, fb);
        check({tag, ":srca_nofwd"}, bus0.SrcAE, cur_e.rd1);
    endtask

    task automatic set_d(input logic valid, input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                         input logic [REG_AW-1:0] rd, input logic [2:0] alu, input logic alu_src,
                         input logic rw, input logic mr, input logic [WIDTH-1:0] rd1,
                         input logic [WIDTH-1:0] rd2, input logic [WIDTH-1:0] imm);
        bus.ValidD = valid;  bus.Rs1D = rs1;  bus.Rs2D = rs2;  bus.RdD = rd;
        bus.ALUControlD = alu;  bus.ALUSrcD = alu_src;  bus.RegWriteD = rw;  bus.MemReadD = mr;
        bus.RD1D = rd1;  bus.RD2D = rd2;  bus.ImmExtD = imm;
    endtask

    task automatic clear_fwd();
        bus.RegWriteM = 1'b0;  bus.RdM = '0;  bus.ALUResultM = '0;
        bus.RegWriteW = 1'b0;  bus.RdW = '0;  bus.ResultW = '0;
    endtask

    // One clock: check StallD against the model, queue the predicted capture, then
    // compare the Execute outputs after the edge. Called just after a falling edge.
    task automatic tick(input string tag);
        e_t  nxt;
        bit  ld_use;
        #1;
        ld_use = cur_e.mr && cur_e.rw && cur_e.rd != 0 && bus.ValidD &&
                 (bus.Rs1D == cur_e.rd || bus.Rs2D == cur_e.rd);
        check({tag, ":stalld"}, bus.StallD, reset_n && ld_use);
        if (!reset_n || bus.FlushE || ld_use) begin
            nxt = '0;
        end else begin
            nxt.rd1 = bus.RD1D;  nxt.rd2 = bus.RD2D;  nxt.imm = bus.ImmExtD;
            nxt.rs1 = bus.Rs1D;  nxt.rs2 = bus.Rs2D;  nxt.rd = bus.RdD;
            nxt.alu = bus.ALUControlD;  nxt.alu_src = bus.ALUSrcD;
            nxt.rw = bus.RegWriteD;  nxt.mr = bus.MemReadD;  nxt.valid = bus.ValidD;
        end
        exp_q.push_back(nxt);
        @(posedge clk);
        #1;
        cur_e = exp_q.pop_front();
        check({tag, ":alu"},   bus.ALUControlE, cur_e.alu);
        check({tag, ":rd"},    bus.RdE, cur_e.rd);
        check({tag, ":rw"},    bus.RegWriteE, cur_e.rw);
        check({tag, ":mr"},    bus.MemReadE, cur_e.mr);
        check({tag, ":valid"}, bus.ValidE, cur_e.valid);
        check_src(tag);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_miss = 0;
        cur_e = '0;
        reset_n = 1'b0;
        bus.FlushE = 1'b0;
        clear_fwd();
        set_d(1, 5'd1, 5'd2, 5'd3, 3'b001, 0, 1, 1, 32'hAAAA_0001, 32'hBBBB_0002, 32'h0000_0040);
        @(negedge clk);

        // Reset held for two cycles with a live Decode instruction.
        tick("rst0");
        tick("rst1");
        check("rst:srca_zero", bus.SrcAE, 32'h0);
        check("rst:valid_zero", bus.ValidE, 1'b0);

        // Release: first capture on the next edge.
        reset_n = 1'b1;
        set_d(1, 5'd1, 5'd2, 5'd3, 3'b000, 0, 1, 0, 32'h0000_0011, 32'h0000_0022, 32'h0);
        tick("cap0");
        check("cap0:srca_raw", bus.SrcAE, 32'h0000_0011);

        // Memory forward, Memory beating Writeback, then Writeback alone.
        set_d(1, 5'd5, 5'd6, 5'd7, 3'b000, 0, 1, 0, 32'h0000_1111, 32'h0000_2222, 32'h10);
        tick("m_cap");
        bus.RegWriteM = 1'b1;  bus.RdM = 5'd5;  bus.ALUResultM = 32'h0000_1234;
        #1;
        check("m_fwd", bus.SrcAE, 32'h0000_1234);
        check("nofwd_raw", bus0.SrcAE, 32'h0000_1111);
        bus.RegWriteW = 1'b1;  bus.RdW = 5'd5;  bus.ResultW = 32'h0000_BEEF;
        #1;
        check("m_over_w", bus.SrcAE, 32'h0000_1234);
        bus.RegWriteM = 1'b0;
        #1;
        check("w_fwd", bus.SrcAE, 32'h0000_BEEF);
        check_src("fwd_mix");
        clear_fwd();

        // x0 is never forwarded; immediate selected for SrcB.
        set_d(1, 5'd0, 5'd0, 5'd8, 3'b010, 1, 1, 0, 32'h0, 32'h0, 32'hFFFF_FFFC);
        tick("x0_cap");
        bus.RegWriteM = 1'b1;  bus.RdM = 5'd0;  bus.ALUResultM = 32'h0000_DEAD;
        #1;
        check("x0_srca", bus.SrcAE, 32'h0);
        check("x0_srcb_imm", bus.SrcBE, 32'hFFFF_FFFC);
        clear_fwd();

        // Load-use: lw x3 then add x4,x3,x1 -> one stall cycle, a bubble, then capture.
        set_d(1, 5'd2, 5'd0, 5'd3, 3'b000, 1, 1, 1, 32'h100, 32'h0, 32'h8);
        tick("lu_lw");
        set_d(1, 5'd3, 5'd1, 5'd4, 3'b000, 0, 1, 0, 32'h0000_0333, 32'h0000_0001, 32'h0);
        #1;
        check("lu_stall_hi", bus.StallD, 1'b1);
        tick("lu_bubble");
        check("lu_bubble_valid", bus.ValidE, 1'b0);
        tick("lu_cap");
        check("lu_stall_lo", bus.StallD, 1'b0);
        bus.RegWriteW = 1'b1;  bus.RdW = 5'd3;  bus.ResultW = 32'h0000_CAFE;
        #1;
        check("lu_w_fwd", bus.SrcAE, 32'h0000_CAFE);
        check("lu_valid", bus.ValidE, 1'b1);
        clear_fwd();

        // Flush of a valid sub.
        set_d(1, 5'd1, 5'd2, 5'd9, 3'b001, 0, 1, 0, 32'h5, 32'h6, 32'h0);
        bus.FlushE = 1'b1;
        tick("flush");
        check("flush_valid", bus.ValidE, 1'b0);
        check("flush_rw", bus.RegWriteE, 1'b0);
        check("flush_alu", bus.ALUControlE, 3'b000);
        bus.FlushE = 1'b0;

        // Flush during a load-use hazard: bubble and StallD still high.
        set_d(1, 5'd2, 5'd0, 5'd6, 3'b000, 1, 1, 1, 32'h200, 32'h0, 32'h4);
        tick("fl_lw");
        set_d(1, 5'd1, 5'd6, 5'd7, 3'b011, 0, 1, 0, 32'h7, 32'h8, 32'h0);
        bus.FlushE = 1'b1;
        #1;
        check("fl_lu_stall", bus.StallD, 1'b1);
        tick("fl_lu");
        check("fl_lu_valid", bus.ValidE, 1'b0);
        bus.FlushE = 1'b0;

        // Reset asserted mid-stall: StallD drops immediately, E cleared on the edge.
        set_d(1, 5'd2, 5'd0, 5'd6, 3'b000, 1, 1, 1, 32'h300, 32'h0, 32'h4);
        tick("rs_lw");
        set_d(1, 5'd6, 5'd1, 5'd7, 3'b000, 0, 1, 0, 32'h7, 32'h8, 32'h0);
        reset_n = 1'b0;
        #1;
        check("rs_stall_lo", bus.StallD, 1'b0);
        tick("rs_clear");
        check("rs_mr", bus.MemReadE, 1'b0);
        reset_n = 1'b1;

        // Randomised traffic over a small register range to provoke hazards.
        for (int i = 0; i < 80; i++) begin
            set_d(1'($urandom_range(0, 3) != 0), REG_AW'($urandom_range(0, 3)),
                  REG_AW'($urandom_range(0, 3)), REG_AW'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom, $urandom, $urandom);
            bus.FlushE = ($urandom_range(0, 7) == 0);
            bus.RegWriteM = 1'($urandom_range(0, 1));  bus.RdM = REG_AW'($urandom_range(0, 3));
            bus.ALUResultM = $urandom;
            bus.RegWriteW = 1'($urandom_range(0, 1));  bus.RdW = REG_AW'($urandom_range(0, 3));
            bus.ResultW = $urandom;
            tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
